// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared key codes, playfield limits and direction type for the paddle block
package pong_pkg;

   localparam logic [7:0] KEY_W  = 8'h1A;
   localparam logic [7:0] KEY_S  = 8'h16;
   localparam logic [7:0] KEY_UP = 8'h52;
   localparam logic [7:0] KEY_DN = 8'h51;

   localparam int Y_MIN    = 20;
   localparam int Y_MAX    = 461;
   localparam int Y_CENTER = 240;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   // Opposing keys cancel; a key may sit in either HID slot.
   function automatic dir_t key_dir(input logic [7:0] k0, input logic [7:0] k1,
                                    input logic [7:0] up_key, input logic [7:0] dn_key);
      logic up;
      logic dn;
      up = (k0 == up_key) || (k1 == up_key);
      dn = (k0 == dn_key) || (k1 == dn_key);
      if (up && !dn)
         return DIR_UP;
      else if (dn && !up)
         return DIR_DN;
      else
         return DIR_NONE;
   endfunction

endpackage

// File: rtl/paddle_axis.sv
// rtl/paddle_axis.sv - one paddle's Y register with velocity ramp and playfield clamp
module paddle_axis
   import pong_pkg::*;
#(
   parameter int MIN_STEP    = 2,
   parameter int MAX_STEP    = 8,
   parameter int RAMP_FRAMES = 8,
   parameter int PAD_L       = 40
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       resetB,
   input  dir_t       dir,
   output logic [9:0] y_pos
);

   localparam int Y_LO = Y_MIN + PAD_L;
   localparam int Y_HI = Y_MAX - PAD_L;

   logic [3:0]        speed_q, speed_d;
   logic [3:0]        count_q, count_d;
   dir_t              prev_q, prev_d;
   logic [9:0]        y_d;
   logic [3:0]        step;
   logic signed [10:0] y_next;

   always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
         y_pos   <= 10'(Y_CENTER);
         speed_q <= 4'(MIN_STEP);
         count_q <= '0;
         prev_q  <= DIR_NONE;
      end else begin
         y_pos   <= y_d;
         speed_q <= speed_d;
         count_q <= count_d;
         prev_q  <= prev_d;
      end
   end

   always_comb begin
      speed_d = speed_q;
      count_d = count_q;
      prev_d  = dir;
      step    = '0;
      y_next  = $signed({1'b0, y_pos});
      y_d     = y_pos;
      if (resetB) begin
         y_d     = 10'(Y_CENTER);
         speed_d = 4'(MIN_STEP);
         count_d = '0;
         prev_d  = DIR_NONE;
      end else begin
         if (dir == DIR_NONE) begin
            speed_d = 4'(MIN_STEP);
            count_d = '0;
         end else if (dir != prev_q) begin
            step    = 4'(MIN_STEP);
            speed_d = 4'(MIN_STEP);
            count_d = 4'd1;
         end else begin
            // This frame moves at the old speed; the bump applies from the next frame.
            step = speed_q;
            if (count_q + 4'd1 == 4'(RAMP_FRAMES)) begin
               count_d = '0;
               speed_d = (speed_q < 4'(MAX_STEP)) ? speed_q + 4'd1 : speed_q;
            end else begin
               count_d = count_q + 4'd1;
            end
         end
         if (dir == DIR_UP)
            y_next = y_next - $signed({7'b0, step});
         else if (dir == DIR_DN)
            y_next = y_next + $signed({7'b0, step});
         if (y_next < $signed(11'(Y_LO)))
            y_d = 10'(Y_LO);
         else if (y_next > $signed(11'(Y_HI)))
            y_d = 10'(Y_HI);
         else
            y_d = y_next[9:0];
      end
   end

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - keycode decode to two paddle positions; PADDLE_AI_EN makes paddle 2 track BallY
module paddle_ctrl
   import pong_pkg::*;
#(
   parameter int P1_X        = 40,
   parameter int P2_X        = 589,
   parameter int PAD_L       = 40,
   parameter int PAD_W       = 4,
   parameter int MIN_STEP    = 2,
   parameter int MAX_STEP    = 8,
   parameter int RAMP_FRAMES = 8,
   parameter int AI_STEP     = 3
) (
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode0,
   input  logic [7:0] keycode1,
   input  logic       resetB,
   input  logic [9:0] BallY,
   output logic [9:0] Paddle1X,
   output logic [9:0] Paddle1Y,
   output logic [9:0] Paddle2X,
   output logic [9:0] Paddle2Y,
   output logic [9:0] Paddle1L,
   output logic [9:0] Paddle2L,
   output logic [9:0] Paddle1W,
   output logic [9:0] Paddle2W
);

   dir_t dir1, dir2;

   assign Paddle1X = 10'(P1_X);
   assign Paddle2X = 10'(P2_X);
   assign Paddle1L = 10'(PAD_L);
   assign Paddle2L = 10'(PAD_L);
   assign Paddle1W = 10'(PAD_W);
   assign Paddle2W = 10'(PAD_W);

   assign dir1 = key_dir(keycode0, keycode1, KEY_W, KEY_S);

`ifdef PADDLE_AI_EN
   // Equal min/max step pins the AI paddle to a constant speed.
   localparam int P2_MIN = AI_STEP;
   localparam int P2_MAX = AI_STEP;

   always_comb begin
      dir2 = DIR_NONE;
      if ({1'b0, BallY} > ({1'b0, Paddle2Y} + 11'd4))
         dir2 = DIR_DN;
      else if (({1'b0, BallY} + 11'd4) < {1'b0, Paddle2Y})
         dir2 = DIR_UP;
   end
`else
   localparam int P2_MIN = MIN_STEP;
   localparam int P2_MAX = MAX_STEP;

   logic unused_bally;
   assign unused_bally = ^{BallY, AI_STEP[0]};
   assign dir2 = key_dir(keycode0, keycode1, KEY_UP, KEY_DN);
`endif

   paddle_axis #(
      .MIN_STEP(MIN_STEP), .MAX_STEP(MAX_STEP), .RAMP_FRAMES(RAMP_FRAMES), .PAD_L(PAD_L)
   ) u_axis1 (
      .frame_clk(frame_clk), .Reset(Reset), .resetB(resetB), .dir(dir1), .y_pos(Paddle1Y)
   );

   paddle_axis #(
      .MIN_STEP(P2_MIN), .MAX_STEP(P2_MAX), .RAMP_FRAMES(RAMP_FRAMES), .PAD_L(PAD_L)
   ) u_axis2 (
      .frame_clk(frame_clk), .Reset(Reset), .resetB(resetB), .dir(dir2), .y_pos(Paddle2Y)
   );

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - directed and randomized checks of paddle_ctrl against a frame-level model
module tb_paddle_ctrl;

   logic       Reset = 1'b0;
   logic       frame_clk = 1'b0;
   logic [7:0] keycode0 = 8'h00;
   logic [7:0] keycode1 = 8'h00;
   logic       resetB = 1'b0;
   logic [9:0] BallY = 10'd240;
   logic [9:0] Paddle1X, Paddle1Y, Paddle2X, Paddle2Y;
   logic [9:0] Paddle1L, Paddle2L, Paddle1W, Paddle2W;

   int checks = 0;
   int errors = 0;

   int my[2];
   int msp[2];
   int mcnt[2];
   int mprev[2];

   logic [7:0] keyset [6] = '{8'h00, 8'h1A, 8'h16, 8'h52, 8'h51, 8'h04};

   paddle_ctrl dut (
      .Reset(Reset), .frame_clk(frame_clk), .keycode0(keycode0), .keycode1(keycode1),
      .resetB(resetB), .BallY(BallY),
      .Paddle1X(Paddle1X), .Paddle1Y(Paddle1Y), .Paddle2X(Paddle2X), .Paddle2Y(Paddle2Y),
      .Paddle1L(Paddle1L), .Paddle2L(Paddle2L), .Paddle1W(Paddle1W), .Paddle2W(Paddle2W)
   );

   always #5 frame_clk = ~frame_clk;

   task automatic check(input string tag, input logic [9:0] obs, input int exp);
      checks++;
      assert (obs === 10'(exp)) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // -1 = up (Y shrinks), +1 = down, 0 = none
   function automatic int kdir(input logic [7:0] up_key, input logic [7:0] dn_key);
      bit up, dn;
      up = (keycode0 == up_key) || (keycode1 == up_key);
      dn = (keycode0 == dn_key) || (keycode1 == dn_key);
      return (up == dn) ? 0 : (up ? -1 : 1);
   endfunction

   task automatic model_reset();
      for (int p = 0; p < 2; p++) begin
         my[p] = 240; msp[p] = 2; mcnt[p] = 0; mprev[p] = 0;
      end
   endtask

   task automatic model_edge();
      int d[2];
      int mv;
      d[0] = kdir(8'h1A, 8'h16);
`ifdef PADDLE_AI_EN
      d[1] = (int'(BallY) > my[1] + 4) ? 1 : ((int'(BallY) < my[1] - 4) ? -1 : 0);
`else
      d[1] = kdir(8'h52, 8'h51);
`endif
      for (int p = 0; p < 2; p++) begin
         if (resetB) begin
            my[p] = 240; msp[p] = 2; mcnt[p] = 0; mprev[p] = 0;
         end else begin
            mv = 0;
            if (d[p] == 0) begin
               msp[p] = 2; mcnt[p] = 0;
            end else if (d[p] != mprev[p]) begin
               mv = 2; msp[p] = 2; mcnt[p] = 1;
            end else begin
               mv = msp[p];
               mcnt[p]++;
               if (mcnt[p] == 8) begin
                  mcnt[p] = 0;
                  msp[p] = (msp[p] + 1 > 8) ? 8 : msp[p] + 1;
               end
            end
`ifdef PADDLE_AI_EN
            if (p == 1) mv = (d[1] != 0) ? 3 : 0;
`endif
            my[p] = my[p] + d[p] * mv;
            if (my[p] < 60) my[p] = 60;
            if (my[p] > 421) my[p] = 421;
            mprev[p] = d[p];
         end
      end
   endtask

   // One frame: model follows the edge, outputs sampled 1 time unit later.
   task automatic frame(input string tag);
      @(posedge frame_clk);
      model_edge();
      #1;
      check({tag, "_p1y"}, Paddle1Y, my[0]);
      check({tag, "_p2y"}, Paddle2Y, my[1]);
   endtask

   task automatic set_keys(input logic [7:0] a, input logic [7:0] b, input logic rb);
      keycode0 = a;
      keycode1 = b;
      resetB   = rb;
   endtask

   initial begin
      #1 Reset = 1'b1;
      #2;
      model_reset();
      check("rst_p1y", Paddle1Y, 240);
      check("rst_p2y", Paddle2Y, 240);
      check("p1x", Paddle1X, 40);
      check("p2x", Paddle2X, 589);
      check("p1l", Paddle1L, 40);
      check("p2l", Paddle2L, 40);
      check("p1w", Paddle1W, 4);
      check("p2w", Paddle2W, 4);
      @(negedge frame_clk);
      Reset = 1'b0;

      for (int i = 0; i < 10; i++) frame("idle");
      check("idle_p1y", Paddle1Y, 240);

      set_keys(8'h1A, 8'h00, 1'b0);
      frame("w1");
      check("w_f1", Paddle1Y, 238);
      for (int i = 2; i <= 8; i++) frame("w");
      check("w_f8", Paddle1Y, 224);
      frame("w9");
      check("w_f9", Paddle1Y, 221);
      for (int i = 0; i < 8; i++) frame("w_ramp");

      set_keys(8'h00, 8'h16, 1'b0);
      for (int i = 0; i < 60; i++) frame("s_clamp");
      check("clamp_lo_edge", Paddle1Y, 421);
      set_keys(8'h1A, 8'h00, 1'b0);
      for (int i = 0; i < 70; i++) frame("w_clamp");
      check("clamp_hi_edge", Paddle1Y, 60);

      set_keys(8'h52, 8'h51, 1'b0);
      for (int i = 0; i < 4; i++) frame("p2_cancel");
      set_keys(8'h16, 8'h52, 1'b0);
      for (int i = 0; i < 12; i++) frame("both");
      set_keys(8'h52, 8'h16, 1'b0);
      for (int i = 0; i < 12; i++) frame("swap_slots");

      set_keys(8'h16, 8'h00, 1'b0);
      for (int i = 0; i < 30; i++) frame("s_ramp");
      set_keys(8'h16, 8'h00, 1'b1);
      frame("resetb");
      check("resetb_p1y", Paddle1Y, 240);
      check("resetb_p2y", Paddle2Y, 240);
      set_keys(8'h16, 8'h00, 1'b0);
      frame("after_rb");
      check("after_rb_p1y", Paddle1Y, 242);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 5) == 0)
            set_keys(keyset[$urandom_range(0, 5)], keyset[$urandom_range(0, 5)], 1'b0);
         resetB = ($urandom_range(0, 39) == 0);
         BallY  = 10'($urandom_range(0, 479));
         frame("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
